// File: rtl/vexec_pkg.sv
// Shared types and helpers for the multi-cycle SIMD execute unit.
package vexec_pkg;

    // Widest lane supported by the immediate sign-extension helper.
    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLL  = 3'd5,
        OP_SRL  = 3'd6,
        OP_MINU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SRC_REG  = 2'd0,
        SRC_FWD  = 2'd1,
        SRC_IMM  = 2'd2,
        SRC_ZERO = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Sign-extend the low imm_w bits of imm to MAX_W bits (caller truncates to lane width).
    function automatic logic [MAX_W-1:0] sext_imm(input logic [MAX_W-1:0] imm,
                                                  input logic [6:0]       imm_w);
        logic [MAX_W-1:0] keep;
        logic [5:0]       msb;
        logic             sign;
        keep = (MAX_W'(1) << imm_w) - MAX_W'(1);
        msb  = 6'(imm_w - 7'd1);
        sign = imm[msb];
        return (imm & keep) | (sign ? ~keep : '0);
    endfunction

endpackage

// File: rtl/vexec_if.sv
// Request/response bundle between register-read, the execute unit and writeback.
interface vexec_if
    import vexec_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int IMM_W  = 16
) ();
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    op_e                       alu_op;
    src_e                      sel_a;
    src_e                      sel_b;
    logic [LANES*LANE_W-1:0]   op_a;
    logic [LANES*LANE_W-1:0]   op_b;
    logic [LANES*LANE_W-1:0]   fwd_a;
    logic [LANES*LANE_W-1:0]   fwd_b;
    logic [IMM_W-1:0]          imm;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*LANE_W-1:0]   result;
    logic [LANES-1:0]          carry;
    logic                      zero;
    logic                      eq;

    // Upstream/downstream side: issues requests, consumes results.
    modport master (
        output flush, in_valid, alu_op, sel_a, sel_b, op_a, op_b, fwd_a, fwd_b, imm, out_ready,
        input  in_ready, out_valid, result, carry, zero, eq
    );

    // Execute unit side.
    modport slave (
        input  flush, in_valid, alu_op, sel_a, sel_b, op_a, op_b, fwd_a, fwd_b, imm, out_ready,
        output in_ready, out_valid, result, carry, zero, eq
    );
endinterface

// File: rtl/vexec_lane.sv
// Combinational single-lane ALU; carry is carry-out for ADD, borrow for SUB, else 0.
module vexec_lane
    import vexec_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  op_e               op,
    output logic [LANE_W-1:0] y,
    output logic              cout
);
    localparam int SH_W = $clog2(LANE_W);

    logic [LANE_W:0]   sum;
    logic [LANE_W:0]   dif;
    logic [SH_W-1:0]   sh;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};   // top bit set exactly when a < b
    assign sh  = b[SH_W-1:0];

    // Per-lane operation select.
    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_ADD:  begin y = sum[LANE_W-1:0]; cout = sum[LANE_W]; end
            OP_SUB:  begin y = dif[LANE_W-1:0]; cout = dif[LANE_W]; end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << sh;
            OP_SRL:  y = a >> sh;
            OP_MINU: y = dif[LANE_W] ? a : b;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/vexec_unit.sv
// Multi-cycle SIMD execute unit: LANES x LANE_W op in LANES/CHUNK beats, CHUNK lanes per beat.
module vexec_unit
    import vexec_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int CHUNK  = 1,
    parameter int IMM_W  = 16
) (
    input  logic    clk,
    input  logic    rst,
    vexec_if.slave  bus
);
    localparam int BEATS = LANES / CHUNK;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (CHUNK < 1 || (LANES % CHUNK) != 0) begin : g_bad_chunk
            $error("vexec_unit: CHUNK must divide LANES");
        end
        if (LANE_W > MAX_W || IMM_W > LANE_W) begin : g_bad_width
            $error("vexec_unit: need IMM_W <= LANE_W <= MAX_W");
        end
    endgenerate

    // Vector viewed as beats of chunks so the active beat is a single index.
    typedef logic [BEATS-1:0][CHUNK-1:0][LANE_W-1:0] vec_t;
    typedef logic [BEATS-1:0][CHUNK-1:0]             flg_t;

    state_e                           state, state_nxt;
    logic [BW-1:0]                    beat;
    op_e                              op_q;
    vec_t                             a_q, b_q, res_q, res_nxt;
    flg_t                             cy_q, cy_nxt;
    logic                             zero_q, eq_q;
    logic [LANE_W-1:0]                imm_lane;
    vec_t                             src_a, src_b;
    logic                             accept, step, last;
    logic                             in_ready, out_valid;
    logic [CHUNK-1:0][LANE_W-1:0]     y_chunk;
    logic [CHUNK-1:0]                 c_chunk;

    assign imm_lane = LANE_W'(sext_imm(MAX_W'(bus.imm), 7'(IMM_W)));

    function automatic vec_t pick(input src_e s, input vec_t r, input vec_t f,
                                  input logic [LANE_W-1:0] im);
        case (s)
            SRC_REG: return r;
            SRC_FWD: return f;
            SRC_IMM: return {LANES{im}};
            default: return '0;
        endcase
    endfunction

    // Operand source resolution; only sampled on accept.
    always_comb begin
        src_a = pick(bus.sel_a, bus.op_a, bus.fwd_a, imm_lane);
        src_b = pick(bus.sel_b, bus.op_b, bus.fwd_b, imm_lane);
    end

    for (genvar c = 0; c < CHUNK; c++) begin : g_lane
        vexec_lane #(.LANE_W(LANE_W)) u_lane (
            .a    (a_q[beat][c]),
            .b    (b_q[beat][c]),
            .op   (op_q),
            .y    (y_chunk[c]),
            .cout (c_chunk[c])
        );
    end

    // Merge this beat's chunk into the result so zero can see the final vector.
    always_comb begin
        res_nxt       = res_q;
        cy_nxt        = cy_q;
        res_nxt[beat] = y_chunk;
        cy_nxt[beat]  = c_chunk;
    end

    // Next-state and handshake decode; flush overrides everything.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (beat == BW'(BEATS - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            step      = 1'b0;
            last      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, beat counter and result/flag accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat   <= '0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            cy_q   <= '0;
            zero_q <= 1'b0;
            eq_q   <= 1'b0;
        end else if (bus.flush) begin
            beat <= '0;
        end else if (accept) begin
            op_q   <= bus.alu_op;
            a_q    <= src_a;
            b_q    <= src_b;
            eq_q   <= (src_a == src_b);
            zero_q <= 1'b0;
            beat   <= '0;
        end else if (step) begin
            res_q <= res_nxt;
            cy_q  <= cy_nxt;
            beat  <= last ? '0 : beat + BW'(1);
            if (last) zero_q <= (res_nxt == '0);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = res_q;
    assign bus.carry     = cy_q;
    assign bus.zero      = zero_q;
    assign bus.eq        = eq_q;

endmodule
